// File: rtl/nm_demux_pkg.sv
// Shared lane/nibble definitions for the nibble-mayor selector and demux pair.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: nibble/id widths, lane id constants, nibble_t / lane_id_t types.
package nm_demux_pkg;

    localparam int NM_NW = 4;  // nibble width
    localparam int NM_IW = 2;  // lane id width

    typedef logic [NM_NW-1:0] nibble_t;
    typedef logic [NM_IW-1:0] lane_id_t;

    localparam lane_id_t NM_ID_A = 2'd0;
    localparam lane_id_t NM_ID_B = 2'd1;
    localparam lane_id_t NM_ID_C = 2'd2;
    localparam lane_id_t NM_ID_D = 2'd3;

    localparam int NM_LANES = 4;

endpackage

// File: rtl/nm_demux_if.sv
// Producer-side (nibble, id) stream into the demux.
// Latency: n/a (wires only).
// Backpressure: in_ready is driven by the demux; a transfer happens when in_valid & in_ready.
// Modports: master = producer (drives in_valid/nibble_in/id_in), slave = demux (drives in_ready).
interface nm_demux_if;
    import nm_demux_pkg::*;

    logic     in_valid;
    logic     in_ready;
    nibble_t  nibble_in;
    lane_id_t id_in;

    modport master (output in_valid, output nibble_in, output id_in, input in_ready);
    modport slave  (input in_valid, input nibble_in, input id_in, output in_ready);

endinterface

// File: rtl/nmd_lane_fifo.sv
// Per-lane FIFO of nibbles with registered head output.
// Latency: pushed entry appears on dout/valid the cycle after the push edge (no bypass).
// Backpressure: push ignored while full (even with a same-cycle pop); pop ignored while empty.
// Ports: clk, reset_L (async active-low), push, pop, din -> dout, valid, full.
// DEPTH must be a power of 2 and >= 2 so the pointers wrap naturally.
module nmd_lane_fifo
    import nm_demux_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset_L,
    input  logic    push,
    input  logic    pop,
    input  nibble_t din,
    output nibble_t dout,
    output logic    valid,
    output logic    full
);

    localparam int PW = $clog2(DEPTH);

    nibble_t         mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign valid   = (count != '0);
    // A full lane refuses the push outright, so a same-cycle pop only frees a slot for next cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & valid;
    // Head is forced to zero when empty so stale contents never leak out.
    assign dout    = valid ? mem[rd_ptr] : '0;

    // Storage is not reset; only the bookkeeping is.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nm_demux.sv
// Routes a (nibble, id) stream back out to four independently drained lane FIFOs A..D.
// Latency: 1 cycle from push edge to lane head; in_ready is combinational on id_in and lane state.
// Backpressure: in_ready = ~full of the addressed lane; lanes pop independently via pop_X.
// Ports: clk, reset_L, in_bus (nm_demux_if.slave), per-lane nibble_X/valid_X/full_X out, pop_X in.
// Option NM_DEMUX_MAXTRACK_EN adds max_A..max_D: largest nibble pushed into each lane since reset.
module nm_demux
    import nm_demux_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset_L,
    nm_demux_if.slave     in_bus,
    output nibble_t       nibble_A,
    output nibble_t       nibble_B,
    output nibble_t       nibble_C,
    output nibble_t       nibble_D,
    output logic          valid_A,
    output logic          valid_B,
    output logic          valid_C,
    output logic          valid_D,
    input  logic          pop_A,
    input  logic          pop_B,
    input  logic          pop_C,
    input  logic          pop_D,
    output logic          full_A,
    output logic          full_B,
    output logic          full_C,
    output logic          full_D
`ifdef NM_DEMUX_MAXTRACK_EN
    ,
    output nibble_t       max_A,
    output nibble_t       max_B,
    output nibble_t       max_C,
    output nibble_t       max_D
`endif
);

    logic [NM_LANES-1:0] push;
    logic [NM_LANES-1:0] pop;
    logic [NM_LANES-1:0] valid;
    logic [NM_LANES-1:0] full;
    nibble_t             head [NM_LANES];
    logic                accept;

    assign pop = {pop_D, pop_C, pop_B, pop_A};

    // Deliberately independent of in_valid so the producer can probe readiness per id.
    assign in_bus.in_ready = ~full[in_bus.id_in];
    assign accept          = in_bus.in_valid & ~full[in_bus.id_in];

    for (genvar i = 0; i < NM_LANES; i++) begin : g_lane
        assign push[i] = accept & (in_bus.id_in == lane_id_t'(i));

        nmd_lane_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .reset_L (reset_L),
            .push    (push[i]),
            .pop     (pop[i]),
            .din     (in_bus.nibble_in),
            .dout    (head[i]),
            .valid   (valid[i]),
            .full    (full[i])
        );
    end

    assign nibble_A = head[NM_ID_A];
    assign nibble_B = head[NM_ID_B];
    assign nibble_C = head[NM_ID_C];
    assign nibble_D = head[NM_ID_D];
    assign valid_A  = valid[NM_ID_A];
    assign valid_B  = valid[NM_ID_B];
    assign valid_C  = valid[NM_ID_C];
    assign valid_D  = valid[NM_ID_D];
    assign full_A   = full[NM_ID_A];
    assign full_B   = full[NM_ID_B];
    assign full_C   = full[NM_ID_C];
    assign full_D   = full[NM_ID_D];

`ifdef NM_DEMUX_MAXTRACK_EN
    nibble_t max_q [NM_LANES];

    // Only accepted pushes count; a refused push on a full lane leaves the max alone.
    for (genvar i = 0; i < NM_LANES; i++) begin : g_max
        always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) begin
                max_q[i] <= '0;
            end else if (push[i] && (in_bus.nibble_in > max_q[i])) begin
                max_q[i] <= in_bus.nibble_in;
            end
        end
    end

    assign max_A = max_q[NM_ID_A];
    assign max_B = max_q[NM_ID_B];
    assign max_C = max_q[NM_ID_C];
    assign max_D = max_q[NM_ID_D];
`endif

endmodule

// File: tb/tb_nm_demux.sv
// Self-checking bench for nm_demux: directed scenarios then random traffic against a queue model.
// Latency: model expects heads one cycle after the push edge.
// Backpressure: model refuses pushes to lanes holding DEPTH entries.
module tb_nm_demux;
    import nm_demux_pkg::*;

    localparam int DEPTH = 4;

    logic    clk;
    logic    reset_L;
    logic    pop_A, pop_B, pop_C, pop_D;
    nibble_t nibble_A, nibble_B, nibble_C, nibble_D;
    logic    valid_A, valid_B, valid_C, valid_D;
    logic    full_A, full_B, full_C, full_D;
`ifdef NM_DEMUX_MAXTRACK_EN
    nibble_t max_A, max_B, max_C, max_D;
`endif

    nm_demux_if bus ();

    nm_demux #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_L  (reset_L),
        .in_bus   (bus.slave),
        .nibble_A (nibble_A),
        .nibble_B (nibble_B),
        .nibble_C (nibble_C),
        .nibble_D (nibble_D),
        .valid_A  (valid_A),
        .valid_B  (valid_B),
        .valid_C  (valid_C),
        .valid_D  (valid_D),
        .pop_A    (pop_A),
        .pop_B    (pop_B),
        .pop_C    (pop_C),
        .pop_D    (pop_D),
        .full_A   (full_A),
        .full_B   (full_B),
        .full_C   (full_C),
        .full_D   (full_D)
`ifdef NM_DEMUX_MAXTRACK_EN
        ,
        .max_A    (max_A),
        .max_B    (max_B),
        .max_C    (max_C),
        .max_D    (max_D)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    nibble_t    o_nib [4];
    logic [3:0] o_vld;
    logic [3:0] o_full;
    assign o_nib[0] = nibble_A;
    assign o_nib[1] = nibble_B;
    assign o_nib[2] = nibble_C;
    assign o_nib[3] = nibble_D;
    assign o_vld    = {valid_D, valid_C, valid_B, valid_A};
    assign o_full   = {full_D, full_C, full_B, full_A};
`ifdef NM_DEMUX_MAXTRACK_EN
    nibble_t o_max [4];
    assign o_max[0] = max_A;
    assign o_max[1] = max_B;
    assign o_max[2] = max_C;
    assign o_max[3] = max_D;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: one FIFO queue per lane plus running maximum.
    nibble_t mq   [4][$];
    nibble_t mmax [4];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < 4; l++) begin
            mq[l].delete();
            mmax[l] = 4'h0;
        end
    endtask

    task automatic check_lanes(input string where);
        for (int l = 0; l < 4; l++) begin
            chk($sformatf("%s valid[%0d]", where, l), {7'd0, o_vld[l]}, {7'd0, mq[l].size() != 0});
            chk($sformatf("%s full[%0d]", where, l), {7'd0, o_full[l]}, {7'd0, mq[l].size() == DEPTH});
            chk($sformatf("%s nibble[%0d]", where, l), {4'd0, o_nib[l]},
                {4'd0, (mq[l].size() != 0) ? mq[l][0] : 4'h0});
`ifdef NM_DEMUX_MAXTRACK_EN
            chk($sformatf("%s max[%0d]", where, l), {4'd0, o_max[l]}, {4'd0, mmax[l]});
`endif
        end
    endtask

    // One clock cycle: drive at negedge, check in_ready, update model at posedge, check at next negedge.
    task automatic cyc(input logic v, input nibble_t n, input lane_id_t id, input logic [3:0] pops,
                       input string where);
        bit push_ok [4];
        bit pop_ok  [4];
        bus.in_valid  = v;
        bus.nibble_in = n;
        bus.id_in     = id;
        {pop_D, pop_C, pop_B, pop_A} = pops;
        #1;
        chk({where, " in_ready"}, {7'd0, bus.in_ready}, {7'd0, mq[id].size() < DEPTH});
        @(posedge clk);
        for (int l = 0; l < 4; l++) begin
            push_ok[l] = v && (int'(id) == l) && (mq[l].size() < DEPTH);
            pop_ok[l]  = pops[l] && (mq[l].size() != 0);
        end
        for (int l = 0; l < 4; l++) begin
            if (pop_ok[l]) void'(mq[l].pop_front());
            if (push_ok[l]) begin
                mq[l].push_back(n);
                if (n > mmax[l]) mmax[l] = n;
            end
        end
        @(negedge clk);
        check_lanes(where);
    endtask

    task automatic drain(input string where);
        for (int k = 0; k < 2 * DEPTH; k++) begin
            if (mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size() == 0) break;
            cyc(1'b0, 4'h0, 2'd0, 4'hF, where);
        end
        chk({where, " drained"}, {7'd0, valid_A | valid_B | valid_C | valid_D}, 8'd0);
    endtask

    initial begin
        nibble_t exp_pop;

        model_reset();
        reset_L       = 1'b0;
        bus.in_valid  = 1'b1;
        bus.nibble_in = 4'hA;
        bus.id_in     = NM_ID_A;
        {pop_D, pop_C, pop_B, pop_A} = 4'h0;

        // 1: reset holds everything empty even with in_valid asserted
        repeat (3) @(negedge clk);
        check_lanes("t1 reset");
        chk("t1 reset in_ready", {7'd0, bus.in_ready}, 8'd1);
        reset_L      = 1'b1;
        bus.in_valid = 1'b0;
        cyc(1'b0, 4'h0, 2'd0, 4'h0, "t1 post");

        // 2: routing by id
        cyc(1'b1, 4'h9, NM_ID_A, 4'h0, "t2 a");
        cyc(1'b1, 4'h3, NM_ID_B, 4'h0, "t2 b");
        cyc(1'b1, 4'hF, NM_ID_C, 4'h0, "t2 c");
        cyc(1'b1, 4'h6, NM_ID_D, 4'h0, "t2 d");
        chk("t2 nibble_A", {4'd0, nibble_A}, 8'h09);
        chk("t2 nibble_B", {4'd0, nibble_B}, 8'h03);
        chk("t2 nibble_C", {4'd0, nibble_C}, 8'h0F);
        chk("t2 nibble_D", {4'd0, nibble_D}, 8'h06);
        chk("t2 all valid", {4'd0, o_vld}, 8'h0F);
        drain("t2 drain");

        // 3: fill lane B, fifth push is backpressured
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, nibble_t'(i + 1), NM_ID_B, 4'h0, "t3 fill");
        chk("t3 full_B", {7'd0, full_B}, 8'd1);
        cyc(1'b1, 4'h5, NM_ID_B, 4'h0, "t3 fifth");
        bus.id_in = NM_ID_B;
        #1 chk("t3 in_ready id1", {7'd0, bus.in_ready}, 8'd0);
        bus.id_in = NM_ID_A;
        #1 chk("t3 in_ready id0", {7'd0, bus.in_ready}, 8'd1);

        // 4: full lane with simultaneous pop refuses the push, accepts next cycle
        cyc(1'b1, 4'h7, NM_ID_B, 4'b0010, "t4 pop+push");
        chk("t4 full_B after refuse", {7'd0, full_B}, 8'd0);
        chk("t4 head_B after pop", {4'd0, nibble_B}, 8'h02);
        cyc(1'b1, 4'h7, NM_ID_B, 4'h0, "t4 retry");
        chk("t4 full_B after retry", {7'd0, full_B}, 8'd1);
        drain("t4 drain");

        // 5: streaming through lane A wraps the pointers twice
        cyc(1'b1, 4'h1, NM_ID_A, 4'h0, "t5 first");
        for (int i = 2; i <= 8; i++) begin
            exp_pop = nibble_t'(i - 1);
            chk("t5 head order", {4'd0, nibble_A}, {4'd0, exp_pop});
            cyc(1'b1, nibble_t'(i), NM_ID_A, 4'b0001, "t5 stream");
            chk("t5 never full", {7'd0, full_A}, 8'd0);
        end
        chk("t5 last head", {4'd0, nibble_A}, 8'h08);
        cyc(1'b0, 4'h0, NM_ID_A, 4'b0001, "t5 last pop");

        // 6: underflow ignored, then max tracking on lane D
        cyc(1'b0, 4'h0, NM_ID_D, 4'b1000, "t6 underflow");
        chk("t6 valid_D", {7'd0, valid_D}, 8'd0);
        cyc(1'b1, 4'h5, NM_ID_D, 4'h0, "t6 push5");
`ifdef NM_DEMUX_MAXTRACK_EN
        chk("t6 max_D 5", {4'd0, max_D}, 8'h05);
`endif
        cyc(1'b1, 4'hC, NM_ID_D, 4'h0, "t6 pushC");
`ifdef NM_DEMUX_MAXTRACK_EN
        chk("t6 max_D C", {4'd0, max_D}, 8'h0C);
`endif
        cyc(1'b1, 4'h2, NM_ID_D, 4'h0, "t6 push2");
`ifdef NM_DEMUX_MAXTRACK_EN
        chk("t6 max_D keep", {4'd0, max_D}, 8'h0C);
`endif
        chk("t6 head_D", {4'd0, nibble_D}, 8'h05);

        // Mid-operation reset discards everything asynchronously
        cyc(1'b1, 4'hE, NM_ID_C, 4'h0, "rst pre");
        #2 reset_L = 1'b0;
        #1 model_reset();
        check_lanes("rst async");
        @(negedge clk);
        bus.in_valid = 1'b1;
        reset_L = 1'b1;
        cyc(1'b1, 4'hB, NM_ID_C, 4'h0, "rst first push");
        chk("rst head_C", {4'd0, nibble_C}, 8'h0B);
        drain("rst drain");

        // Random traffic against the queue model
        for (int k = 0; k < 400; k++) begin
            logic [3:0] pops;
            for (int l = 0; l < 4; l++) pops[l] = ($urandom_range(0, 2) == 0);
            cyc($urandom_range(0, 3) != 0, nibble_t'($urandom), lane_id_t'($urandom), pops, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
